// File: rtl/int_to_float_if.sv
// Sample-in / float-out STB/ACK bundle for int_to_float.
// slave = the converter, master = the upstream producer plus downstream consumer.
interface int_to_float_if #(
    parameter int IN_WIDTH = 24
);
    logic [IN_WIDTH-1:0] a;
    logic                a_stb;
    logic                a_ack;
    logic [31:0]         z;
    logic                z_stb;
    logic                z_ack;

    modport slave (
        input  a,
        input  a_stb,
        output a_ack,
        output z,
        output z_stb,
        input  z_ack
    );

    modport master (
        output a,
        output a_stb,
        input  a_ack,
        input  z,
        input  z_stb,
        output z_ack
    );
endinterface

// File: rtl/int_to_float.sv
// Signed integer sample to IEEE-754 single, round to nearest even, one sample in flight.
// Latency: 5 + leading zeros of |a| cycles (2 for zero) from the accept edge to z_stb.
// Backpressure: z held with z_stb until z_ack; no new sample accepted meanwhile.
module int_to_float #(
    parameter int IN_WIDTH = 24
) (
    input  logic           i_CLK,
    input  logic           i_RSTN,
    int_to_float_if.slave  bus
);

    typedef enum logic [2:0] {
        GET_A,
        CONVERT,
        NORMALISE,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t             state;
    logic               a_ack_r;
    logic               z_stb_r;
    logic [31:0]        z_out;
    logic [31:0]        a_r;
    logic [31:0]        m;
    logic [7:0]         e;
    logic               s;
    logic [23:0]        mant;
    logic [31:0]        z_r;

    logic signed [IN_WIDTH-1:0] a_in;
    logic signed [31:0]         a_ext;
    logic                       round_up;

    assign a_in  = bus.a;
    assign a_ext = 32'(a_in);

    // guard && (round | sticky | lsb): ties go to the even mantissa
    assign round_up = m[7] & (m[6] | (|m[5:0]) | m[8]);

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state   <= GET_A;
            a_ack_r <= 1'b0;
            z_stb_r <= 1'b0;
            z_out   <= 32'h0;
            a_r     <= 32'h0;
            m       <= 32'h0;
            e       <= 8'h0;
            s       <= 1'b0;
            mant    <= 24'h0;
            z_r     <= 32'h0;
        end else begin
            case (state)
                GET_A: begin
                    if (a_ack_r && bus.a_stb) begin
                        a_r     <= a_ext;
                        a_ack_r <= 1'b0;
                        state   <= CONVERT;
                    end else begin
                        a_ack_r <= 1'b1;
                    end
                end
                CONVERT: begin
                    s <= a_r[31];
                    m <= a_r[31] ? (~a_r + 32'd1) : a_r;
                    e <= 8'd31;
                    if (a_r == 32'd0) begin
                        z_r   <= 32'h0;
                        state <= PUT_Z;
                    end else begin
                        state <= NORMALISE;
                    end
                end
                NORMALISE: begin
                    if (!m[31]) begin
                        m <= m << 1;
                        e <= e - 8'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (round_up) begin
                        if (&m[31:8]) begin
                            mant <= 24'h800000;
                            e    <= e + 8'd1;
                        end else begin
                            mant <= m[31:8] + 24'd1;
                        end
                    end else begin
                        mant <= m[31:8];
                    end
                    state <= PACK;
                end
                PACK: begin
                    z_r   <= {s, e + 8'd127, mant[22:0]};
                    state <= PUT_Z;
                end
                PUT_Z: begin
                    if (z_stb_r && bus.z_ack) begin
                        z_stb_r <= 1'b0;
                        state   <= GET_A;
                    end else begin
                        z_stb_r <= 1'b1;
                        z_out   <= z_r;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

    assign bus.a_ack = a_ack_r;
    assign bus.z_stb = z_stb_r;
    assign bus.z     = z_out;

endmodule
